// File: rtl/cache_requester.sv
// cache_requester: one-at-a-time valid/ready command master issuing 1-cycle cache_rd/cache_wr strobes, watchdog, latency and saturating stats
module cache_requester #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [3:0]               cmd_byte_enable,
  input  logic [31:0]              cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_wr,
  output logic                     rsp_timeout,
  output logic [31:0]              rsp_data,
  output logic [ADDRESS_WIDTH-1:0] cache_address,
  output logic                     cache_rd,
  output logic                     cache_wr,
  output logic [3:0]               cache_byte_enable,
  output logic [31:0]              cache_data_wr,
  input  logic [31:0]              cache_data_out,
  input  logic                     cache_ready,
  input  logic                     stats_clear,
  output logic [15:0]              rd_done,
  output logic [15:0]              wr_done,
  output logic [15:0]              timeouts,
  output logic [15:0]              last_latency
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, rd_done_n, wr_done_n, timeouts_n, lat_n;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [3:0] be_n;
  logic [31:0] wdata_n, rsp_data_n;
  logic rd_n, wr_n, rsp_wr_n, rsp_to_n;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + 16'(v != 16'hFFFF);
  endfunction
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = cache_address;
    be_n = cache_byte_enable;
    wdata_n = cache_data_wr;
    rd_n = 1'b0;
    wr_n = 1'b0;
    rsp_wr_n = rsp_wr;
    rsp_to_n = rsp_timeout;
    rsp_data_n = rsp_data;
    rd_done_n = rd_done;
    wr_done_n = wr_done;
    timeouts_n = timeouts;
    lat_n = last_latency;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        state_n = WAIT;
        cnt_n = '0;
        addr_n = cmd_address;
        be_n = cmd_byte_enable;
        wdata_n = cmd_data;
        rd_n = !cmd_wr;
        wr_n = cmd_wr;
        rsp_wr_n = cmd_wr;
      end
      WAIT: if (cache_rd || cache_wr) cnt_n = 16'd1;
      else if (cache_ready) begin
        state_n = RESP;
        rsp_to_n = 1'b0;
        rsp_data_n = rsp_wr ? '0 : cache_data_out;
        lat_n = cnt;
        wr_done_n = rsp_wr ? sat_inc(wr_done) : wr_done;
        rd_done_n = rsp_wr ? rd_done : sat_inc(rd_done);
      end else if (TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES) begin
        state_n = RESP;
        rsp_to_n = 1'b1;
        rsp_data_n = '0;
        timeouts_n = sat_inc(timeouts);
      end else cnt_n = sat_inc(cnt);
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (stats_clear) begin
      rd_done_n = '0;
      wr_done_n = '0;
      timeouts_n = '0;
      lat_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wr <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data <= '0;
      cache_address <= '0;
      cache_rd <= 1'b0;
      cache_wr <= 1'b0;
      cache_byte_enable <= '0;
      cache_data_wr <= '0;
      rd_done <= '0;
      wr_done <= '0;
      timeouts <= '0;
      last_latency <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd_ready <= state_n == IDLE;
      rsp_valid <= state_n == RESP;
      rsp_wr <= rsp_wr_n;
      rsp_timeout <= rsp_to_n;
      rsp_data <= rsp_data_n;
      cache_address <= addr_n;
      cache_rd <= rd_n;
      cache_wr <= wr_n;
      cache_byte_enable <= be_n;
      cache_data_wr <= wdata_n;
      rd_done <= rd_done_n;
      wr_done <= wr_done_n;
      timeouts <= timeouts_n;
      last_latency <= lat_n;
    end
  end
endmodule

// File: tb/tb_cache_requester.sv
// tb_cache_requester: randomized scoreboard bench with a latency-programmable cache stub and a reference memory/counter model
module tb_cache_requester;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [15:0] cmd_address = 0;
  logic [3:0] cmd_byte_enable = 0;
  logic [31:0] cmd_data = 0;
  logic rsp_valid, rsp_ready = 0, rsp_wr, rsp_timeout;
  logic [31:0] rsp_data;
  logic [15:0] cache_address;
  logic cache_rd, cache_wr;
  logic [3:0] cache_byte_enable;
  logic [31:0] cache_data_wr, cache_data_out;
  logic cache_ready;
  logic stats_clear = 0;
  logic [15:0] rd_done, wr_done, timeouts, last_latency;

  cache_requester #(.ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout),
    .rsp_data(rsp_data), .cache_address(cache_address), .cache_rd(cache_rd), .cache_wr(cache_wr),
    .cache_byte_enable(cache_byte_enable), .cache_data_wr(cache_data_wr),
    .cache_data_out(cache_data_out), .cache_ready(cache_ready), .stats_clear(stats_clear),
    .rd_done(rd_done), .wr_done(wr_done), .timeouts(timeouts), .last_latency(last_latency));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { bit wr; logic [15:0] a; logic [3:0] be; logic [31:0] d; int k; } cmd_t;
  typedef struct { bit wr, to; logic [31:0] d; logic [15:0] lat, rd, wc, tc; int dly; } exp_t;
  cmd_t stub_q[$];
  exp_t sb[$];
  int s_q[$];
  logic [31:0] rmem [int];
  logic [31:0] smem [int];
  logic [15:0] mr = 0, mw = 0, mt = 0, ml = 0;
  int rr_mode = 0, stray_cnt = 0, acc_cyc = 0;

  function automatic logic [31:0] init_w(input int i);
    logic [7:0] b = i[7:0];
    return {4{b}};
  endfunction
  function automatic logic [31:0] m_rd(input logic [15:0] a);
    int i = int'(a >> 2);
    return rmem.exists(i) ? rmem[i] : init_w(i);
  endfunction
  function automatic void m_wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w = m_rd(a);
    for (int l = 0; l < 4; l++) if (be[l]) w[8*l+:8] = d[8*l+:8];
    rmem[int'(a >> 2)] = w;
  endfunction
  function automatic logic [31:0] s_rd(input logic [15:0] a);
    int i = int'(a >> 2);
    return smem.exists(i) ? smem[i] : init_w(i);
  endfunction
  function automatic void s_wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w = s_rd(a);
    for (int l = 0; l < 4; l++) if (be[l]) w[8*l+:8] = d[8*l+:8];
    smem[int'(a >> 2)] = w;
  endfunction
  function automatic logic [15:0] sat(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  // k = cycles after the strobe at which the stub answers; 0 = never, k > TO answers too late
  task automatic issue(input bit wr, input logic [15:0] a, input logic [3:0] be, input logic [31:0] d, input int k, input bit clr);
    exp_t e;
    cmd_t c;
    int n = 0;
    bit to = (k == 0 || k > TO);
    e.wr = wr;
    e.to = to;
    e.d = (to || wr) ? 32'h0 : m_rd(a);
    if (wr) m_wr(a, be, d);
    if (to) mt = sat(mt);
    else begin
      ml = 16'(k);
      if (wr) mw = sat(mw); else mr = sat(mr);
    end
    if (clr) begin mr = 0; mw = 0; mt = 0; ml = 0; end
    e.lat = ml; e.rd = mr; e.wc = mw; e.tc = mt;
    e.dly = to ? TO : k;
    c.wr = wr; c.a = a; c.be = be; c.d = d; c.k = k;
    sb.push_back(e);
    stub_q.push_back(c);
    @(negedge clk);
    cmd_wr = wr; cmd_address = a; cmd_byte_enable = be; cmd_data = d; cmd_valid = 1;
    if (clr) stats_clear = 1;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    #2 rsp_ready = rr_mode == 1 ? 1'b1 : rr_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin : stub
    int t, fire, seen;
    bit act;
    cmd_t c;
    cache_ready = 0; cache_data_out = 0; act = 0; seen = 0; t = 0; fire = 0;
    forever begin
      @(negedge clk);
      cache_ready = 0;
      cache_data_out = $urandom;
      if (rst) begin act = 0; seen = stray_cnt; continue; end
      if (seen != stray_cnt) begin seen = stray_cnt; cache_ready = 1; end
      if (cache_rd || cache_wr) begin
        if (stub_q.size() == 0) begin chk("unexpected_strobe", 1, 0); continue; end
        c = stub_q.pop_front();
        s_q.push_back(cyc);
        chk("strobe_kind", {30'h0, cache_wr, cache_rd}, c.wr ? 2 : 1);
        chk("cache_addr", cache_address, c.a);
        chk("cache_be", cache_byte_enable, c.be);
        chk("cache_wdata", cache_data_wr, c.d);
        if (c.wr) s_wr(c.a, c.be, c.d);
        act = 1; t = 0; fire = c.k;
      end else if (act) begin
        t++;
        chk("addr_stable", cache_address, c.a);
        chk("wdata_stable", cache_data_wr, c.d);
        if (t == fire) begin
          cache_ready = 1;
          cache_data_out = c.wr ? $urandom : s_rd(c.a);
          act = 0;
        end else if (t > TO) act = 0;
      end
    end
  end

  bit pv = 0, hold = 0, h_wr, h_to;
  logic [31:0] h_d;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin pv = 0; hold = 0; end
    else begin
      if (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_wr", rsp_wr, h_wr);
        chk("hold_to", rsp_timeout, h_to);
        chk("hold_data", rsp_data, h_d);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      if (rsp_valid && !pv && sb.size() != 0 && s_q.size() != 0)
        chk("rsp_delay", cyc - s_q[0], sb[0].dly + 1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          if (s_q.size() != 0) void'(s_q.pop_front());
          chk("rsp_wr", rsp_wr, e.wr);
          chk("rsp_timeout", rsp_timeout, e.to);
          chk("rsp_data", rsp_data, e.d);
          chk("last_latency", last_latency, e.lat);
          chk("rd_done", rd_done, e.rd);
          chk("wr_done", wr_done, e.wc);
          chk("timeouts", timeouts, e.tc);
          chk("rsp_cmd_ready", cmd_ready, 0);
        end
      end
      hold = rsp_valid && !rsp_ready;
      h_wr = rsp_wr; h_to = rsp_timeout; h_d = rsp_data;
      pv = rsp_valid;
    end
  end

  initial begin
    int n, prev;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {30'h0, cache_rd, cache_wr}, 0);
    chk("rst_counters", {rd_done, wr_done}, 0);
    chk("rst_timeouts_lat", {timeouts, last_latency}, 0);
    rst = 0;
    @(posedge clk);
    #1 chk("cmd_ready_after_rst", cmd_ready, 1);
    rr_mode = 1;
    issue(0, 16'h0020, 4'hF, 0, 2, 0);
    drain();
    issue(1, 16'hD030, 4'hF, 32'h0000_1234, 3, 0);
    issue(0, 16'hD030, 4'hF, 0, 1, 0);
    drain();
    rr_mode = 2;
    issue(0, 16'h0026, 4'h3, 0, 4, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("hold_rsp_seen", rsp_valid, 1);
    repeat (5) @(negedge clk);
    rr_mode = 1;
    drain();
    issue(0, 16'h0030, 4'hF, 0, 0, 0);
    issue(1, 16'h0034, 4'h5, 32'hA5A5_5A5A, TO + 1, 0);
    issue(1, 16'h0038, 4'h0, 32'hFFFF_FFFF, TO, 0);
    drain();
    stray_cnt++;
    repeat (6) @(negedge clk);
    chk("stray_rd", rd_done, mr);
    chk("stray_wr", wr_done, mw);
    chk("stray_to", timeouts, mt);
    chk("stray_no_rsp", rsp_valid, 0);
    issue(0, 16'h0010, 4'hF, 0, 1, 0);
    prev = acc_cyc;
    for (int i = 1; i < 20; i++) begin
      issue(0, 16'(4 * (i % 16)), 4'hF, 0, 1, 0);
      chk("b2b_spacing", acc_cyc - prev, 4);
      prev = acc_cyc;
    end
    drain();
    @(negedge clk);
    stats_clear = 1;
    @(negedge clk);
    stats_clear = 0;
    mr = 0; mw = 0; mt = 0; ml = 0;
    chk("clr_counters", {rd_done, wr_done}, 0);
    chk("clr_timeouts_lat", {timeouts, last_latency}, 0);
    issue(0, 16'h0008, 4'hF, 0, 3, 1);
    drain();
    stats_clear = 0;
    rr_mode = 0;
    for (int i = 0; i < 150; i++)
      issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 4'($urandom), $urandom, $urandom_range(0, TO + 1), 0);
    drain();
    rr_mode = 1;
    @(negedge clk);
    cmd_wr = 0; cmd_address = 16'h0044; cmd_byte_enable = 4'hF; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #2 chk("strobe_before_rst", cache_rd, 1);
    rst = 1;
    cmd_valid = 0;
    #1;
    chk("arst_strobes", {30'h0, cache_rd, cache_wr}, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_counters", {rd_done, wr_done}, 0);
    mr = 0; mw = 0; mt = 0; ml = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 chk("cmd_ready_after_arst", cmd_ready, 1);
    issue(0, 16'h0040, 4'hF, 0, 2, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_requester.md
# cache_requester

Synthesizable request master for the device side of the cache interface, the initiator that the `direct_mapped` and `fully_associative` caches respond to. It accepts one command at a time from an upstream valid/ready port and issues it to the cache as a single-cycle `cache_rd`/`cache_wr` strobe. It waits for `cache_ready`, then returns the read data or write completion on a valid/ready response port. It also provides a watchdog timeout, per-transaction latency measurement and saturating statistics counters, and serves as the bus master for CPU-less bring-up and cache traffic benches.

## Interface
- ADDRESS_WIDTH, 16, byte address width; must match the attached cache.
- TIMEOUT_CYCLES, 256, cycles after the strobe within which `cache_ready` must arrive; 0 disables the timeout.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  upstream command present.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_wr  input  1  1 = write, 0 = read.
- cmd_address  input  ADDRESS_WIDTH  byte address.
- cmd_byte_enable  input  4  byte lanes.
- cmd_data  input  32  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  upstream takes the response.
- rsp_wr  output  1  echo of cmd_wr.
- rsp_timeout  output  1  transaction ended by watchdog.
- rsp_data  output  32  read data; 0 for writes and timeouts.
- cache_address  output  ADDRESS_WIDTH  to cache.
- cache_rd, cache_wr  output  1 each  one-cycle request strobes.
- cache_byte_enable  output  4  to cache.
- cache_data_wr  output  32  to cache.
- cache_data_out  input  32  read data from cache; valid in the `cache_ready` cycle.
- cache_ready  input  1  completion pulse from cache.
- stats_clear  input  1  synchronous clear of all counters.
- rd_done, wr_done, timeouts  output  16 each  saturating transaction counters.
- last_latency  output  16  strobe-to-ready cycles of the last completed transaction, saturating at 0xFFFF.

## Operation
- FSM states are IDLE, WAIT and RESP; all outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On acceptance (cmd_valid & cmd_ready), latch address, byte_enable, data and wr into the cache_* registers.
  - Set cache_rd or cache_wr to 1, clear the latency counter, go to WAIT.
- WAIT:
  - The first WAIT cycle is the strobe cycle; the strobe clears after it, so each strobe lasts exactly 1 cycle.
  - cache_ready is ignored in the strobe cycle and sampled in every later WAIT cycle.
  - cache_address, cache_byte_enable and cache_data_wr hold stable for the whole of WAIT.
  - On ready: rsp_data = cache_data_out for reads, 0 for writes; rsp_timeout=0; last_latency = cycles since the strobe; increment rd_done or wr_done; go to RESP.
  - Watchdog (TIMEOUT_CYCLES≠0): if no ready arrives within TIMEOUT_CYCLES cycles after the strobe, set rsp_timeout=1, rsp_data=0, increment timeouts, go to RESP. last_latency is unchanged.
- RESP:
  - rsp_valid=1, and all rsp_* are held stable until rsp_ready.
  - On handshake, go to IDLE.
  - cmd_ready=0 in both WAIT and RESP.
- cache_ready in IDLE or RESP is a late or stray pulse and is discarded with no state change.
- Addresses pass through unaligned and unmodified. A write with byte_enable=0 is still issued.
- Counters:
  - Saturate at 0xFFFF.
  - stats_clear zeroes rd_done, wr_done, timeouts and last_latency next edge. If an increment coincides with stats_clear, clear wins.
- Reset:
  - All outputs are 0 (including cmd_ready, strobes and counters); state is IDLE.
  - Reset mid-transaction aborts it immediately with no response; the strobes drop asynchronously.

## Timing
- Acceptance edge T; strobe high during cycle T+1.
- Ready sampled at S+k (S = strobe cycle, 1 ≤ k ≤ TIMEOUT_CYCLES) gives rsp_valid from S+k+1 and last_latency=k.
- Minimum transaction: accept T, strobe T+1, ready T+2, rsp_valid T+3, rsp_ready at T+3, cmd_ready T+4. Command-to-command spacing is therefore ≥4 cycles.
- Timeout: rsp_valid at S+TIMEOUT_CYCLES+1.
- cmd_ready goes to 1 in the first cycle after reset deasserts.

## Test plan
- Read 0x0020, BE=F, through `direct_mapped` + `simulated_ram` → rsp_data=0x08080808, rsp_wr=0, rsp_timeout=0, rd_done=1, cache_rd high exactly 1 cycle.
- Write 0xD030 data 0x00001234 BE=F, then read 0xD030 → write response rsp_data=0; read returns 0x00001234; wr_done=1, rd_done=1. Address and data stay stable through WAIT.
- Hold rsp_ready low 5 cycles after rsp_valid → rsp_* held constant, cmd_ready=0, exactly one response consumed, counters incremented once.
- Stub cache that never asserts ready, TIMEOUT_CYCLES=8 → rsp_timeout=1 at S+9, rsp_data=0, timeouts=1. A stray ready injected in IDLE causes no response and no counter change.
- Stub ready at S+1 over 20 back-to-back reads with rsp_ready=1 → cmd_ready period 4 cycles, last_latency=1, rd_done=20. stats_clear then gives all counters 0.
- Assert rst during WAIT → cache_rd/cache_wr/rsp_valid/cmd_ready drop to 0 immediately, counters 0. After release: cmd_ready=1 next cycle, and a fresh read of 0x0040 returns 0x10101010.
